// File: rtl/conf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conf_pkg
// Description : Shared constants, field widths and FSM encoding for the
//               RS232 configuration-frame sender.
// Revision    : 1.0 - initial release
// ============================================================================
package conf_pkg;

  // Payload byte count (command byte excluded)
  localparam int CONF_NBYTES = 11;

  // Register field widths
  localparam int CONF_W_CTRL = 8;
  localparam int CONF_W_FMOD = 24;
  localparam int CONF_W_FPOR = 24;
  localparam int CONF_W_AM   = 16;
  localparam int CONF_W_FM   = 16;

  // Shadow holds the command byte followed by the payload, MSB first
  localparam int CONF_SHADOW_W = 8 + CONF_W_CTRL + CONF_W_FMOD + CONF_W_FPOR +
                                 CONF_W_AM + CONF_W_FM;
  localparam int CONF_IDX_W    = 4;

  // Default command bytes
  localparam logic [7:0] CONF_WR_CMD = 8'h57;
  localparam logic [7:0] CONF_RD_CMD = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_FINISH  = 3'd4,
    S_RB_RX   = 3'd5
  } conf_state_e;

endpackage
`default_nettype wire

// File: rtl/conf_byte_mux.sv
`default_nettype none
// ============================================================================
// Module      : conf_byte_mux
// Description : Picks byte i_idx (0 = command byte) out of the frame shadow,
//               most significant byte first. Shared by the transmit and
//               readback-compare paths.
// Revision    : 1.0 - initial release
// ============================================================================
module conf_byte_mux
  import conf_pkg::*;
(
  input  logic [CONF_SHADOW_W-1:0] i_shadow,
  input  logic [CONF_IDX_W-1:0]    i_idx,
  output logic [7:0]               o_byte
);

  localparam int c_NB_TOTAL = CONF_NBYTES + 1;

  // Byte select; out-of-range indices read as zero
  always_comb begin
    o_byte = '0;
    for (int k = 0; k < c_NB_TOTAL; k++) begin
      if (i_idx == CONF_IDX_W'(k)) begin
        o_byte = i_shadow[8*(c_NB_TOTAL-1-k) +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conf_sender.sv
`default_nettype none
// ============================================================================
// Module      : conf_sender
// Description : Snapshots the configuration register set and sends it as a
//               12-byte write frame through a byte-level UART transmitter.
//               Optional macro CONF_SENDER_READBACK_EN adds a readback phase
//               (RD_CMD, then 11 echoed bytes compared against the snapshot).
// Revision    : 1.0 - initial release
// ============================================================================
module conf_sender
  import conf_pkg::*;
#(
  parameter logic [7:0]  WR_CMD  = CONF_WR_CMD,
  parameter logic [7:0]  RD_CMD  = CONF_RD_CMD,
  parameter int unsigned TIMEOUT = 69440
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CONF_W_CTRL-1:0] r_control,
  input  logic [CONF_W_FMOD-1:0] r_frec_mod,
  input  logic [CONF_W_FPOR-1:0] r_frec_por,
  input  logic [CONF_W_AM-1:0]   r_im_am,
  input  logic [CONF_W_FM-1:0]   r_im_fm,
  output logic [7:0]             txdw,
  output logic                   txena,
  input  logic                   txbusy,
  input  logic [7:0]             rxdw,
  input  logic                   rxrdy,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  conf_state_e               r_state;
  logic [CONF_IDX_W-1:0]     r_idx;
  logic [CONF_SHADOW_W-1:0]  r_shadow;
  logic [7:0]                w_byte;
  logic [7:0]                w_tx_byte;

  conf_byte_mux u_mux (
    .i_shadow (r_shadow),
    .i_idx    (r_idx),
    .o_byte   (w_byte)
  );

`ifdef CONF_SENDER_READBACK_EN
  localparam int c_TW = $clog2(TIMEOUT + 1);

  logic            r_rb;     // set while the RD_CMD byte is in flight
  logic            r_err;
  logic [c_TW-1:0] r_timer;  // cycles since the last echoed byte

  assign w_tx_byte = r_rb ? RD_CMD : w_byte;
  assign err       = r_err;
`else
  logic w_unused_rb;

  assign w_unused_rb = ^{rxdw, rxrdy, RD_CMD, TIMEOUT};
  assign w_tx_byte   = w_byte;
  assign err         = 1'b0;
`endif

  // Frame sequencer: handshake with the transmitter, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_shadow <= '0;
      txdw     <= '0;
      txena    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef CONF_SENDER_READBACK_EN
      r_rb     <= 1'b0;
      r_err    <= 1'b0;
      r_timer  <= '0;
`endif
    end else begin
      txena <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shadow <= {WR_CMD, r_control, r_frec_mod, r_frec_por, r_im_am, r_im_fm};
            r_idx    <= '0;
            busy     <= 1'b1;
            r_state  <= S_SEND;
`ifdef CONF_SENDER_READBACK_EN
            r_rb     <= 1'b0;
            r_err    <= 1'b0;
`endif
          end
        end
        S_SEND: begin
          if (!txbusy) begin
            txdw    <= w_tx_byte;
            txena   <= 1'b1;
            r_state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (txbusy) begin
            r_state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!txbusy) begin
`ifdef CONF_SENDER_READBACK_EN
            if (r_rb) begin
              // RD_CMD is out: echo of payload byte 1 is compared first
              r_rb    <= 1'b0;
              r_idx   <= CONF_IDX_W'(1);
              r_timer <= '0;
              r_state <= S_RB_RX;
            end else if (r_idx == CONF_IDX_W'(CONF_NBYTES)) begin
              r_rb    <= 1'b1;
              r_state <= S_SEND;
            end else begin
              r_idx   <= r_idx + CONF_IDX_W'(1);
              r_state <= S_SEND;
            end
`else
            if (r_idx == CONF_IDX_W'(CONF_NBYTES)) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_idx   <= r_idx + CONF_IDX_W'(1);
              r_state <= S_SEND;
            end
`endif
          end
        end
`ifdef CONF_SENDER_READBACK_EN
        S_RB_RX: begin
          if (rxrdy) begin
            r_timer <= '0;
            if (rxdw != w_byte) begin
              r_err <= 1'b1;
            end
            if (r_idx == CONF_IDX_W'(CONF_NBYTES)) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_idx <= r_idx + CONF_IDX_W'(1);
            end
          end else if (r_timer == c_TW'(TIMEOUT)) begin
            r_err   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_FINISH;
          end else begin
            r_timer <= r_timer + c_TW'(1);
          end
        end
`endif
        // Holds off one cycle so a start coincident with done is dropped
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conf_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_conf_sender
// Description : Scoreboard bench for conf_sender with a transmitter model.
//               Honours CONF_SENDER_READBACK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conf_sender;

  localparam int unsigned TB_TIMEOUT = 300;
  localparam int          BUDGET     = 3000;
`ifdef CONF_SENDER_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  r_control;
  logic [23:0] r_frec_mod, r_frec_por;
  logic [15:0] r_im_am, r_im_fm;
  logic [7:0]  txdw, rxdw;
  logic        txena, txbusy, rxrdy, busy, done, err;
  logic        hold_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int tx_count = 0;
  int done_cnt = 0;
  int tx_cnt   = 0;
  bit stab_on = 0, stab_hi = 0, prev_done = 0;
  logic [7:0] stab_byte = 8'h00;

  always #5 clk = ~clk;

  conf_sender #(.WR_CMD(8'h57), .RD_CMD(8'h52), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .r_control(r_control), .r_frec_mod(r_frec_mod), .r_frec_por(r_frec_por),
    .r_im_am(r_im_am), .r_im_fm(r_im_fm),
    .txdw(txdw), .txena(txena), .txbusy(txbusy),
    .rxdw(rxdw), .rxrdy(rxrdy),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=no-event expected=event", nm);
  endtask

  // UART transmitter model: busy for a random 1..6 cycles per byte
  always @(posedge clk) begin
    if (txena) tx_cnt <= $urandom_range(1, 6);
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign txbusy = hold_busy | (tx_cnt != 0);

  // Monitor: pops the scoreboard on each transmit strobe
  always @(negedge clk) begin
    if (rst) begin
      stab_on   = 0;
      prev_done = 0;
    end else begin
      if (txena) begin
        chk("txena_while_busy", {31'd0, txbusy}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_byte actual=%0h expected=none", txdw);
        end else begin
          chk("tx_byte", {24'd0, txdw}, {24'd0, exp_q.pop_front()});
        end
        tx_count++;
        stab_on   = 1;
        stab_hi   = 0;
        stab_byte = txdw;
      end else if (stab_on) begin
        if (txbusy) stab_hi = 1;
        else if (stab_hi) stab_on = 0;
        if (stab_on) chk("txdw_hold", {24'd0, txdw}, {24'd0, stab_byte});
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("done_width", {31'd0, prev_done}, 32'd0);
      end
      prev_done = done;
    end
  end

  task automatic set_inputs(input logic [7:0] c, input logic [23:0] fmo, input logic [23:0] fpo,
                            input logic [15:0] am, input logic [15:0] fm);
    r_control  = c;
    r_frec_mod = fmo;
    r_frec_por = fpo;
    r_im_am    = am;
    r_im_fm    = fm;
  endtask

  // mode: 0 no echo, 1 correct echo, 2 echo with frame byte 3 zeroed
  task automatic run_frame(input logic [7:0] c, input logic [23:0] fmo, input logic [23:0] fpo,
                           input logic [15:0] am, input logic [15:0] fm, input int mode,
                           input bit scramble, input int hold, input bit extra, input bit at_done);
    logic [7:0] f[$];
    int  t0, d0, n, seen;
    bit  exp_err;
    f.push_back(8'h57);
    f.push_back(c);
    for (int i = 2; i >= 0; i--) f.push_back(fmo[8*i +: 8]);
    for (int i = 2; i >= 0; i--) f.push_back(fpo[8*i +: 8]);
    for (int i = 1; i >= 0; i--) f.push_back(am[8*i +: 8]);
    for (int i = 1; i >= 0; i--) f.push_back(fm[8*i +: 8]);
    foreach (f[i]) exp_q.push_back(f[i]);
    if (RB_EN) exp_q.push_back(8'h52);
    exp_err = RB_EN && (mode != 1);

    t0 = tx_count;
    d0 = done_cnt;
    if (hold > 0) hold_busy = 1'b1;
    set_inputs(c, fmo, fpo, am, fm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("err_cleared_on_start", {31'd0, err}, 32'd0);
    if (scramble) set_inputs(8'h00, 24'h0, 24'h0, 16'h0, 16'h0);
    if (hold == 0 && !txbusy) begin
      @(negedge clk);
      chk("first_txena_latency", {31'd0, txena}, 32'd1);
    end
    if (hold > 0) begin
      seen = 0;
      repeat (hold) begin
        @(negedge clk);
        if (txena) seen++;
      end
      chk("no_txena_while_held", seen, 0);
      hold_busy = 1'b0;
    end
    if (extra) begin
      n = 0;
      while (tx_count < t0 + 4 && n < BUDGET) begin @(negedge clk); n++; end
      set_inputs(8'hFF, 24'hFFFFFF, 24'hFFFFFF, 16'hFFFF, 16'hFFFF);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
`ifdef CONF_SENDER_READBACK_EN
    n = 0;
    while (tx_count < t0 + 13 && n < BUDGET) begin @(negedge clk); n++; end
    @(negedge clk);
    while (txbusy && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) fail_to("rd_cmd_wait");
    repeat (2) @(negedge clk);
    if (mode != 0) begin
      for (int i = 1; i < 12; i++) begin
        rxdw  = (mode == 2 && i == 3) ? 8'h00 : f[i];
        rxrdy = 1'b1;
        @(negedge clk);
        rxrdy = 1'b0;
        rxdw  = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
`endif
    n = 0;
    while (!done && n < BUDGET) begin @(negedge clk); n++; end
    if (!done) fail_to("done_wait");
    if (at_done) begin
      t0 = tx_count;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_with_done_ignored", {31'd0, busy}, 32'd0);
      repeat (20) @(negedge clk);
      chk("no_bytes_after_done_start", tx_count, t0);
    end else begin
      @(negedge clk);
    end
    chk("done_count", done_cnt, d0 + 1);
    chk("frame_complete", exp_q.size(), 0);
    chk("err_at_done", {31'd0, err}, {31'd0, exp_err});
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t0, d0, n;
    rst = 1'b1; start = 1'b0; rxdw = 8'h00; rxrdy = 1'b0; hold_busy = 1'b0;
    set_inputs(8'h00, 24'h0, 24'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_txdw",  {24'd0, txdw}, 32'd0);
    chk("rst_txena", {31'd0, txena}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic write, plus start coincident with done
    run_frame(8'hA5, 24'h123456, 24'hABCDEF, 16'h0F0F, 16'hF00F, 1, 0, 0, 0, 1);
    // Snapshot: inputs cleared one cycle after start
    run_frame(8'h3C, 24'h8899AA, 24'h010203, 16'hBEEF, 16'h1234, 1, 1, 0, 0, 0);
    // Busy guard and ignored mid-frame start
    run_frame(8'h5A, 24'hC0FFEE, 24'h13579B, 16'h2468, 16'hACE1, 1, 0, 50, 1, 0);

    // Reset mid-frame after byte 4
    foreach (exp_q[i]) exp_q.delete(i);
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h00);
    exp_q.delete();
    t0 = tx_count;
    d0 = done_cnt;
    set_inputs(8'h11, 24'h223344, 24'h556677, 16'h8899, 16'hAABB);
    exp_q.push_back(8'h57); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (tx_count < t0 + 5 && n < BUDGET) begin @(negedge clk); n++; end
    if (tx_count < t0 + 5) fail_to("reset_mid_wait");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_txena", {31'd0, txena}, 32'd0);
    chk("rst_mid_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (60) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, d0);
    run_frame(8'hA5, 24'h123456, 24'hABCDEF, 16'h0F0F, 16'hF00F, 1, 0, 0, 0, 0);

    // Random frames
    for (int k = 0; k < 6; k++) begin
      run_frame(8'($urandom), 24'($urandom), 24'($urandom), 16'($urandom), 16'($urandom),
                1, 1'($urandom_range(0, 1)), 0, 0, 0);
    end

`ifdef CONF_SENDER_READBACK_EN
    // Corrupted echo, then no echo (timeout), then a clean frame clears err
    run_frame(8'hA5, 24'h123456, 24'hABCDEF, 16'h0F0F, 16'hF00F, 2, 0, 0, 0, 0);
    run_frame(8'h77, 24'h0A0B0C, 24'h0D0E0F, 16'h1111, 16'h2222, 0, 0, 0, 0, 0);
    run_frame(8'h99, 24'h010101, 24'h020202, 16'h0303, 16'h0404, 1, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conf_sender.md
# conf_sender

Host-side initiator for the RS232 configuration link: snapshots a full register set (control, modulating frequency, carrier frequency, AM index, FM index) and serialises it as a write frame of one command byte plus 11 payload bytes into a byte-level UART transmitter. It sits between the stimulus or configuration source and an `RS232COM` instance, driving its `txdw`/`txena` and honouring `txbusy`. It is the write-side counterpart of the board's configuration receiver. An optional readback phase requests the registers back and checks them.

## Interface
Parameters:
- `WR_CMD`, default `8'h57`: write-frame command byte.
- `RD_CMD`, default `8'h52`: readback command byte (used only with readback compiled in).
- `TIMEOUT`, default `69440`: maximum clk cycles allowed between readback bytes (10 bits × 434 cpb × 16).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to send the frame; ignored while `busy`=1.
- `r_control`  in  8  control register value.
- `r_frec_mod`  in  24  modulating-frequency word.
- `r_frec_por`  in  24  carrier-frequency word.
- `r_im_am`  in  16  AM index.
- `r_im_fm`  in  16  FM index.
- `txdw`  out  8  byte to the transmitter.
- `txena`  out  1  one-cycle transmit strobe.
- `txbusy`  in  1  transmitter busy.
- `rxdw`  in  8  received byte (readback only).
- `rxrdy`  in  1  received-byte strobe (readback only).
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame completion.
- `err`  out  1  readback mismatch or timeout; sticky until the next accepted `start`.

## Operation
- Reset values: `txdw`=0, `txena`=0, `busy`=0, `done`=0, `err`=0, FSM in IDLE, byte index=0.
- Byte order: `WR_CMD`, `r_control`, `r_frec_mod[23:16]`, `[15:8]`, `[7:0]`, `r_frec_por` (MSB first), `r_im_am` (MSB first), `r_im_fm` (MSB first). Total 12 bytes.
- The snapshot is latched into a 96-bit shadow on the cycle `start` is accepted. Input changes after that cycle do not affect the frame.
- FSM states: IDLE → SEND (drive `txdw`, pulse `txena` if `txbusy`=0) → WAIT_HI (until `txbusy`=1) → WAIT_LO (until `txbusy`=0) → SEND for the next byte, or FINISH after byte 11 → IDLE.
- `txena` is never asserted while `txbusy`=1. `txdw` is held stable from the `txena` cycle until `txbusy` falls.
- `start` arriving in the same cycle as `done` is ignored. `start` is accepted only in IDLE.
- `rxrdy` pulses outside the readback receive phase are ignored.
- Reset mid-frame aborts the frame at the next edge. No `done` is produced, and the partially sent frame is the host's responsibility.

## Timing
- `start` sampled at edge N → `busy`=1 and `txena`=1 at N+1, provided `txbusy`=0.
- Per byte, the next `txena` occurs 1 cycle after `txbusy` is seen low in WAIT_LO.
- `done` pulses for exactly one cycle, the cycle after the final byte's `txbusy` fall. `busy` drops in the same cycle as `done`.

## Configuration
- `CONF_SENDER_READBACK_EN` defined: after the write frame, FINISH is replaced by this sequence:
  - RB_CMD: send `RD_CMD` with the same handshake.
  - RB_RX: accept 11 `rxrdy` bytes, comparing each with the shadow in the same byte order.
  - Any mismatch sets `err`. More than `TIMEOUT` cycles without `rxrdy` sets `err` and ends the phase.
  - `done` follows the 11th byte or the timeout.
- Macro undefined: `rxdw`/`rxrdy` are unused, there is no readback logic, and `err` is held at 0.

## Structure
- Shared package `conf_pkg`:
  - Byte count constant: `CONF_NBYTES`=11.
  - Field widths: 8/24/24/16/16.
  - FSM state encoding.
  - Default `WR_CMD`/`RD_CMD`.
- One sub-module, `conf_byte_mux`: selects the payload byte from the shadow by index, shared by the transmit and compare paths.

## Test plan
- Basic write: reset, `r_control`=8'hA5, `r_frec_mod`=24'h123456, `r_frec_por`=24'hABCDEF, `r_im_am`=16'h0F0F, `r_im_fm`=16'hF00F, `start` → transmitted bytes are 57, A5, 12, 34, 56, AB, CD, EF, 0F, 0F, F0, 0F, followed by one `done` pulse.
- Snapshot: change every input to 0 one cycle after `start` → the frame still carries the original values.
- Busy guard: hold `txbusy`=1 for 50 cycles before the first byte → no `txena` until `txbusy`=0; a second `start` mid-frame produces no extra bytes.
- Reset mid-frame: assert `rst` after byte 4 → next cycle `txena`=0, `busy`=0, `done` never pulses; a fresh `start` sends a full 12-byte frame.
- Readback match (macro defined): echo the 11 payload bytes on `rxrdy` after `RD_CMD` → `done`=1, `err`=0.
- Readback fault (macro defined): corrupt byte 3 to 8'h00 → `err`=1. With no echo at all → `err`=1 after `TIMEOUT` cycles, and `err` clears on the next `start`.
